// File: rtl/multu_hilo.sv
// Multi-cycle unsigned WIDTHxWIDTH shift-and-add multiplier with the HI/LO pair.
// start/busy/done talk to the control unit; dataOut feeds the ALU result mux for MFHI/MFLO.
module multu_hilo #(
  parameter int          WIDTH = 32,
  parameter logic [5:0]  MULTU = 6'b011001,
  parameter logic [5:0]  MFHI  = 6'b010000,
  parameter logic [5:0]  MFLO  = 6'b010010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic [1:0]       state_dbg
);

  // Handshake: start is only taken in IDLE with Signal==MULTU; busy is high for
  // the WIDTH iteration cycles; done pulses one cycle as HI/LO take the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   mcand, mcand_n;
  logic [2*WIDTH-1:0]   product, product_n;
  logic [2*WIDTH-1:0]   sum;
  logic [WIDTH-1:0]     mplier, mplier_n;
  logic [WIDTH-1:0]     hi, hi_n;
  logic [WIDTH-1:0]     lo, lo_n;
  logic [CW-1:0]        count, count_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      product <= '0;
      mplier  <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      mcand   <= mcand_n;
      product <= product_n;
      mplier  <= mplier_n;
      hi      <= hi_n;
      lo      <= lo_n;
      count   <= count_n;
    end
  end

  always_comb begin
    state_n   = state;
    mcand_n   = mcand;
    product_n = product;
    mplier_n  = mplier;
    hi_n      = hi;
    lo_n      = lo;
    count_n   = count;
    sum       = product + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (start && (Signal == MULTU)) begin
          mcand_n   = {{WIDTH{1'b0}}, dataA};
          mplier_n  = dataB;
          product_n = '0;
          count_n   = '0;
          state_n   = RUN;
        end
      end
      RUN: begin
        product_n = sum;
        mcand_n   = mcand << 1;
        mplier_n  = mplier >> 1;
        count_n   = count + CW'(1);
        // HI/LO take the final sum directly so they never show a partial product.
        if (count == LAST) begin
          hi_n    = sum[2*WIDTH-1:WIDTH];
          lo_n    = sum[WIDTH-1:0];
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    state_dbg = state;
    if (Signal == MFHI)      dataOut = hi;
    else if (Signal == MFLO) dataOut = lo;
    else                     dataOut = '0;
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Randomised self-checking bench for multu_hilo against a cycle-count/product model.
module tb_multu_hilo;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic        start;
  logic        busy, done;
  logic [31:0] dataOut;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  multu_hilo dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .start(start), .busy(busy), .done(done), .dataOut(dataOut), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a product is owed 32 cycles after an accepted start,
  // followed by one done cycle in which new starts are not taken.
  logic [63:0] exp_q[$];
  int          rem = 0;
  bit          m_done = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] exp_out;
  logic [63:0] p;

  always @(posedge clk) begin
    if (reset) begin
      rem = 0; m_done = 0; m_hi = '0; m_lo = '0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        p = exp_q.pop_front();
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_done = 1;
      end
    end else if (start && Signal == MULTU) begin
      exp_q.push_back({32'b0, dataA} * {32'b0, dataB});
      rem = 32;
    end
    #2;
    exp_out = (Signal == MFHI) ? m_hi : (Signal == MFLO) ? m_lo : 32'h0;
    chk("busy", {31'b0, busy}, {31'b0, rem > 0});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("dataOut", dataOut, exp_out);
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_sig();
    case ($urandom_range(0, 3))
      0: Signal = MFHI;
      1: Signal = MFLO;
      2: Signal = MULTU;
      default: Signal = 6'($urandom_range(0, 63));
    endcase
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataA = a; dataB = b; Signal = MULTU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataA = $urandom; dataB = $urandom;
    Signal = MFLO;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 40) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    Signal = MFHI; #1; chk({name, "_hi"}, dataOut, hi);
    Signal = MFLO; #1; chk({name, "_lo"}, dataOut, lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dataA = '0; dataB = '0; Signal = MFHI;
    cyc(2);
    read_hilo("reset", 32'h0, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    launch(32'd3, 32'd5);
    wait_done();
    read_hilo("mul3x5", 32'h0, 32'h0000_000F);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    // start while in DONE must be ignored
    Signal = MULTU; start = 1'b1; dataA = 32'd11; dataB = 32'd13;
    @(negedge clk);
    start = 1'b0;
    read_hilo("mulmax", 32'hFFFF_FFFE, 32'h0000_0001);
    cyc(3);
    chk("done_start_ignored", {31'b0, busy}, 32'h0);

    launch(32'h8000_0000, 32'd2);
    wait_done();
    read_hilo("mulmsb", 32'h0000_0001, 32'h0);

    // mid-run start, stale LO and unused code
    launch(32'd3, 32'd5);
    cyc(8);
    dataA = 32'd7; dataB = 32'd9; Signal = MULTU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Signal = MFLO; #1; chk("mid_old_lo", dataOut, 32'h0);
    Signal = 6'b000000; #1; chk("sig_zero", dataOut, 32'h0);
    wait_done();
    read_hilo("mid_result", 32'h0, 32'h0000_000F);
    cyc(2);

    // reset during a run
    launch(32'd3, 32'd5);
    cyc(10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    read_hilo("rst_mid", 32'h0, 32'h0);
    cyc(40);
    launch(32'd6, 32'd7);
    wait_done();
    read_hilo("mul6x7", 32'h0, 32'd42);

    // randomized traffic with junk starts and random read codes
    for (int i = 0; i < 20; i++) begin
      launch($urandom, (i % 4 == 0) ? 32'h0 : $urandom);
      for (int j = 0; j < 36; j++) begin
        @(negedge clk);
        rand_sig();
        start = ($urandom_range(0, 7) == 0);
        dataA = $urandom; dataB = $urandom;
        if (j == 35) start = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    cyc(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
